// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified memory port arbiter.
// Holds the FSM state enum, owner encoding and watchdog length.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int TIMEOUT_CYC = 64;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory signals of the arbiter.
// slave is the arbiter side; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_done;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_rdata, mem_ack,
    output i_done, d_done, rdata, err,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_be
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_rdata, mem_ack,
    input  i_done, d_done, rdata, err,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_arb_priority.sv
// mem_arb_priority: D-first grant with a starvation bound for I.
// Owns the saturating count of D grants made while I was waiting.
module mem_arb_priority
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic gnt_valid,
  output logic gnt_d
);
  localparam int CW =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q;
  logic          force_i;

  assign force_i   = (cnt_q == CW'(STARVE_MAX));
  assign gnt_valid = arb_en & (i_req | d_req);
  assign gnt_d     = d_req & ~(i_req & force_i);

  // Only counts while I is actually waiting behind a D grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (arb_en) begin
      if (gnt_d && i_req)
        cnt_q <= force_i ? cnt_q : cnt_q + 1'b1;
      else
        cnt_q <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory between fetch (I) and load/store (D).
// Define MEM_PORT_ARB_TIMEOUT_EN to end hung BUSY accesses with err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  state_t            state_q, state_d;
  owner_t            own_q, own_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              idone_q, idone_d;
  logic              ddone_q, ddone_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              arb_en, gnt_valid, gnt_d;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0]   wd_q, wd_d;
`endif

  assign arb_en = (state_q == IDLE);

  mem_arb_priority #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .arb_en   (arb_en),
    .i_req    (bus.i_req),
    .d_req    (bus.d_req),
    .gnt_valid(gnt_valid),
    .gnt_d    (gnt_d)
  );

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    idone_d = 1'b0;
    ddone_d = 1'b0;
    rdata_d = rdata_q;
    err_d   = 1'b0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    wd_d    = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          own_d   = gnt_d ? OWN_D : OWN_I;
          req_d   = 1'b1;
          we_d    = gnt_d & bus.d_we;
          addr_d  = gnt_d ? bus.d_addr : bus.i_addr;
          wdata_d = gnt_d ? bus.d_wdata : '0;
          be_d    = gnt_d ? bus.d_be : '1;
          state_d = BUSY;
        end
      end
      BUSY: begin
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        wd_d = wd_q + 1'b1;
`endif
        if (bus.mem_ack) begin
          req_d   = 1'b0;
          rdata_d = we_q ? '0 : bus.mem_rdata;
          idone_d = (own_q == OWN_I);
          ddone_d = (own_q == OWN_D);
          state_d = RESP;
        end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          req_d   = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
          idone_d = (own_q == OWN_I);
          ddone_d = (own_q == OWN_D);
          state_d = RESP;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      own_q   <= OWN_I;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      idone_q <= 1'b0;
      ddone_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      idone_q <= idone_d;
      ddone_q <= ddone_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.i_done    = idone_q;
  assign bus.d_done    = ddone_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;

endmodule
